// File: rtl/morse_port_bank.sv
// morse_port_bank
// Front-end between the board switches and the core's input ports.
// The raw {op, morse} vector is synchronised through two flops and then
// debounced. Once a value has been stable long enough, differs from the last
// committed snapshot and freeze is low, it is committed. The commit drives
// zero-extended CPU input ports, registered hex nibbles for the 7-segment
// decoders, and a pending/ack change handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   morse      raw symbols; channel i = morse[i*SYM_W +: SYM_W]
//   op         raw operation switches
//   freeze     inhibits commits while high
//   ack        core acknowledges the current snapshot
//   ports_out  port i = zero-extended symbol i; port NCH = zero-extended op
//   digits     one hex nibble per channel
//   pending    snapshot committed and not yet acknowledged
//   new_data   one-cycle pulse after each commit
//   commit_cnt commit counter, wraps modulo 256
module morse_port_bank #(
    parameter int NCH        = 2,
    parameter int SYM_W      = 5,
    parameter int OP_W       = 3,
    parameter int PORT_W     = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH*SYM_W-1:0]       morse,
    input  logic [OP_W-1:0]            op,
    input  logic                       freeze,
    input  logic                       ack,
    output logic [(NCH+1)*PORT_W-1:0]  ports_out,
    output logic [NCH*4-1:0]           digits,
    output logic                       pending,
    output logic                       new_data,
    output logic [7:0]                 commit_cnt
);
    localparam int RW = NCH*SYM_W + OP_W;
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [RW-1:0]    s1, s2, cand, snap;
    logic [CW-1:0]    cnt;
    logic             commit;
    logic [NCH*4-1:0] digits_next;

    // cnt reaching CNT_MAX with s2 == cand means the candidate has been seen
    // on DEB_CYCLES+1 consecutive samples.
    assign commit = (s2 == cand) && (cnt == CNT_MAX) && (cand != snap) && !freeze;

    // Nibbles are taken from the candidate so they land in the digit register
    // on the very edge that loads the snapshot.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        if (SYM_W >= 4) begin : g_top
            assign digits_next[i*4 +: 4] = cand[i*SYM_W + SYM_W - 4 +: 4];
        end else begin : g_ext
            assign digits_next[i*4 +: 4] = 4'(cand[i*SYM_W +: SYM_W]);
        end
        assign ports_out[i*PORT_W +: PORT_W] = PORT_W'(snap[i*SYM_W +: SYM_W]);
    end
    assign ports_out[NCH*PORT_W +: PORT_W] = PORT_W'(snap[RW-1 -: OP_W]);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            cnt        <= '0;
            snap       <= '0;
            digits     <= '0;
            pending    <= 1'b0;
            new_data   <= 1'b0;
            commit_cnt <= 8'd0;
        end else begin
            s1 <= {op, morse};
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            new_data <= commit;
            if (commit) begin
                snap       <= cand;
                digits     <= digits_next;
                commit_cnt <= commit_cnt + 8'd1;
            end
            // A commit on the same edge as an ack wins: the core acked the
            // old snapshot, not the one arriving now.
            if (commit) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_morse_port_bank.sv
module tb_morse_port_bank;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  morse = '0;
    logic [2:0]  op = '0;
    logic        freeze = 1'b0;
    logic        ack = 1'b0;
    logic [23:0] ports_out;
    logic [7:0]  digits;
    logic        pending;
    logic        new_data;
    logic [7:0]  commit_cnt;

    morse_port_bank #(.NCH(2), .SYM_W(5), .OP_W(3), .PORT_W(8), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .morse(morse), .op(op), .freeze(freeze), .ack(ack),
        .ports_out(ports_out), .digits(digits), .pending(pending),
        .new_data(new_data), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: the raw vector delayed two samples, tracked as a run
    // of identical samples; a value that has run DEB+1 samples and differs
    // from the snapshot is committed unless frozen.
    logic [12:0] d1, d2, run_val, m_snap;
    int          run_len;
    logic        m_pend, m_nd, m_commit;
    logic [7:0]  m_cnt;
    bit          model_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            d1 = '0; d2 = '0; run_val = '0; run_len = 1; m_snap = '0;
            m_pend = 0; m_nd = 0; m_cnt = 0; model_valid = 1;
        end else begin
            if (d2 == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = d2;
                run_len = 1;
            end
            m_commit = (run_len >= DEB + 1) && (run_val != m_snap) && !freeze;
            m_nd = m_commit;
            if (m_commit) begin
                m_snap = run_val;
                m_cnt = m_cnt + 8'd1;
                m_pend = 1;
            end else if (ack) begin
                m_pend = 0;
            end
            d2 = d1;
            d1 = {op, morse};
        end
    end

    function automatic logic [23:0] exp_ports(input logic [12:0] k);
        logic [23:0] p = '0;
        for (int i = 0; i < 3; i++) begin
            int v;
            v = (i < 2) ? int'((k >> (5*i)) & 13'h1F) : int'(k >> 10);
            p = p + 24'(v << (8*i));
        end
        return p;
    endfunction

    function automatic logic [7:0] exp_digits(input logic [12:0] k);
        logic [7:0] d = '0;
        for (int i = 0; i < 2; i++) begin
            int sym;
            sym = int'((k >> (5*i)) & 13'h1F);
            d = d + 8'((sym / 2) << (4*i));
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("ports_out", 32'(ports_out), 32'(exp_ports(m_snap)));
            chk("digits", 32'(digits), 32'(exp_digits(m_snap)));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("new_data", 32'(new_data), 32'(m_nd));
            chk("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ports"}, 32'(ports_out), 0);
        chk({tag, "_digits"}, 32'(digits), 0);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_new_data"}, 32'(new_data), 0);
        chk({tag, "_cnt"}, 32'(commit_cnt), 0);
    endtask

    initial begin
        bit got;
        // Reset with all switches high.
        morse = 10'h3FF; op = 3'b111; reset = 1'b1;
        tick(3);
        chk_all_zero("in_reset");
        reset = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (new_data) begin
                got = 1;
                break;
            end
        end
        chk("rst_commit_seen", 32'(got), 1);
        chk("rst_ports", 32'(ports_out), 32'h00071F1F);
        chk("rst_digits", 32'(digits), 32'hFF);
        chk("rst_pending", 32'(pending), 1);
        chk("rst_cnt", 32'(commit_cnt), 1);

        // Clear pending, then measure commit latency.
        ack = 1; tick(1); ack = 0;
        tick(2);
        morse = {5'b10110, 5'b00011}; op = 3'b101;
        tick(6);
        chk("lat_before_ports", 32'(ports_out), 32'h00071F1F);
        tick(1);
        chk("lat_ports", 32'(ports_out), 32'h00051603);
        chk("lat_digits", 32'(digits), 32'hB1);
        chk("lat_new_data", 32'(new_data), 1);
        chk("lat_cnt", 32'(commit_cnt), 2);
        tick(3);

        // Two-cycle glitch on bit 0 that returns.
        morse[0] = 1'b0; tick(2); morse[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            chk("glitch_new_data", 32'(new_data), 0);
        end
        chk("glitch_cnt", 32'(commit_cnt), 2);
        chk("glitch_ports", 32'(ports_out), 32'h00051603);

        // Freeze holds off a stable change.
        ack = 1; tick(1); ack = 0;
        freeze = 1; morse = 10'h2A5;
        tick(20);
        chk("frz_cnt", 32'(commit_cnt), 2);
        chk("frz_pending", 32'(pending), 0);
        freeze = 0;
        tick(1);
        chk("unfrz_cnt", 32'(commit_cnt), 3);
        chk("unfrz_pending", 32'(pending), 1);
        chk("unfrz_new_data", 32'(new_data), 1);
        chk("unfrz_ports", 32'(ports_out), 32'h00051505);

        // Ack coinciding with a commit keeps pending set.
        ack = 1; tick(1); ack = 0;
        morse = 10'h155;
        tick(6);
        ack = 1; tick(1); ack = 0;
        chk("ackc_new_data", 32'(new_data), 1);
        chk("ackc_pending", 32'(pending), 1);
        tick(1);
        ack = 1; tick(1); ack = 0;
        chk("ack_pending", 32'(pending), 0);
        ack = 1; tick(1); ack = 0;
        chk("ack_idle_pending", 32'(pending), 0);
        chk("ack_idle_cnt", 32'(commit_cnt), 4);

        // 256 alternating commits wrap the counter.
        reset = 1; tick(1); reset = 0;
        for (int i = 0; i < 256; i++) begin
            morse = (i % 2 == 0) ? 10'h0AA : 10'h155;
            tick(8);
        end
        chk("wrap_model", 32'(m_cnt), 0);
        chk("wrap_cnt", 32'(commit_cnt), 0);
        chk("wrap_ports", 32'(ports_out), 32'h00050A15);

        // Reset during debounce discards everything.
        morse = 10'h3C3;
        tick(5);
        reset = 1; tick(1);
        chk_all_zero("mid_reset");
        reset = 0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 2) == 0) morse[$urandom_range(0, 9)] ^= 1'b1;
                else morse = 10'($urandom);
                if ($urandom_range(0, 3) == 0) op = 3'($urandom);
            end
            freeze = ($urandom_range(0, 5) == 0);
            ack = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 60) == 0);
            tick($urandom_range(1, 10));
        end
        reset = 0; freeze = 0; ack = 0;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_port_bank.md
# morse_port_bank

Parametrised input front-end between the board switches and the `monociclo` core's input ports. It synchronises and debounces N morse symbol fields plus an operation field, then commits a stable snapshot into zero-padded CPU input ports. A pending/ack handshake tells the core that new data has arrived. It also drives registered hex nibbles for the 7-segment decoders. It generalises the fixed two-symbol, unfiltered input latch to any channel count and symbol width, and adds debounce, freeze and a change handshake.

## Interface
Parameters:
- NCH, 2, number of morse symbol channels (1..8)
- SYM_W, 5, bits per symbol channel (1..PORT_W)
- OP_W, 3, operation field width (1..PORT_W)
- PORT_W, 8, width of each CPU input port
- DEB_CYCLES, 4, consecutive stable cycles required before commit (≥1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- morse  in  NCH*SYM_W  raw switch symbols; channel i = morse[i*SYM_W +: SYM_W], channel NCH-1 is the MSB field
- op  in  OP_W  raw operation switches
- freeze  in  1  when high, commits are inhibited
- ack  in  1  core acknowledges the current snapshot
- ports_out  out  (NCH+1)*PORT_W  port i = zero-extended symbol i; port NCH = zero-extended op
- digits  out  NCH*4  hex nibble per channel, for the deco4a7 instances
- pending  out  1  snapshot committed and not yet acknowledged
- new_data  out  1  one-cycle pulse on each commit
- commit_cnt  out  8  number of commits, wraps 255→0

## Operation
- Raw vector R = {op, morse}. It passes through two sync flops, s1 then s2.
- Candidate register C and stability counter cnt (width clog2(DEB_CYCLES)+1).
  - If s2 ≠ C: load C ← s2 and cnt ← 0.
  - Else, if cnt < DEB_CYCLES-1: cnt ← cnt+1. Otherwise cnt saturates.
- Commit condition: s2 = C, cnt = DEB_CYCLES-1, C ≠ committed snapshot K, and freeze = 0.
- On commit:
  - K ← C.
  - new_data = 1 for that cycle. It is registered and visible the cycle after the edge that updates K.
  - pending ← 1.
  - commit_cnt ← commit_cnt+1, with modulo-256 wrap.
- Identical-value stabilisation: no commit and no pulse. A glitch that returns to K before stable causes no commit.
- freeze: the counter still runs and saturates. When freeze falls and C is still stable and ≠ K, the commit happens on the first edge with freeze = 0.
- Handshake:
  - ack with pending = 1 clears pending.
  - If ack and a commit occur on the same edge, pending stays 1.
  - ack with pending = 0 is ignored.
- Port mapping: port i = {(PORT_W-SYM_W) zeros, K symbol i}. The op port is zero-extended the same way. No sign extension.
- Digits: nibble i = top 4 bits of symbol i when SYM_W ≥ 4. Otherwise it is the symbol zero-extended to 4 bits. The nibbles are registered from K and update on the same edge as ports_out.

## Timing
- Reset (synchronous, priority over everything) clears s1, s2, C, cnt, K, pending, new_data and commit_cnt to 0. Hence ports_out = 0, digits = 0, pending = 0, new_data = 0 and commit_cnt = 0 after the reset edge.
- Reset asserted mid-debounce or mid-handshake discards all state. No commit occurs on the reset edge.
- Latency: a raw change stable from before edge k appears on ports_out after edge k+2+DEB_CYCLES. With defaults, that is edge k+6.
- ports_out, digits and pending change on the same edge. new_data is high for exactly the cycle following that edge.
- Back-to-back commits are spaced at least DEB_CYCLES+1 cycles apart. new_data is never high two consecutive cycles.

## Test plan
- Reset with morse=10'h3FF, op=3'b111 held → all outputs 0 for every cycle reset is high. After release, ports hold 0 until edge 6, then port0=8'h1F, port1=8'h1F, port2=8'h07, digits=8'hFF, pending=1, one new_data pulse, commit_cnt=1.
- morse={5'b10110,5'b00011}, op=3'b101 stable → port1=8'h16, port0=8'h03, port2=8'h05, digits=8'hB1 exactly 6 edges after the change.
- 2-cycle glitch on morse bit 0 that then returns to the previous value → no new_data, commit_cnt unchanged, ports unchanged.
- freeze=1 during a change held 20 cycles → no commit. freeze falls → commit on the next edge and pending=1.
- ack on the same edge as a commit → pending stays 1. A later ack alone → pending=0. A further ack with pending=0 has no effect.
- 256 alternating value commits → commit_cnt wraps to 0. Reset mid-debounce (cnt=2) → no commit, and all outputs are 0 the next cycle.
